// File: rtl/enemy_attack_ctrl_if.sv
`timescale 1ns/1ps
// Bundle between the per-enemy game logic and the attack controller: positions and alive flag in,
// attack status out.
interface enemy_attack_ctrl_if;
  logic       game_frame_clk_rising_edge;
  logic [8:0] player_x;
  logic [8:0] player_y;
  logic [8:0] enemy_x;
  logic [8:0] enemy_y;
  logic       enemy_alive;
  logic       attack_on;
  logic       attack_valid;
  logic [1:0] attack_direction;
  logic [7:0] attack_count;

  modport master (
    output game_frame_clk_rising_edge, player_x, player_y, enemy_x, enemy_y, enemy_alive,
    input  attack_on, attack_valid, attack_direction, attack_count
  );

  modport slave (
    input  game_frame_clk_rising_edge, player_x, player_y, enemy_x, enemy_y, enemy_alive,
    output attack_on, attack_valid, attack_direction, attack_count
  );
endinterface

// File: rtl/enemy_attack_ctrl.sv
`timescale 1ns/1ps
// Per-enemy attack initiator: proximity-gated wind-up / one-frame strike / cooldown, paced by frame ticks.
// Optional macro ENEMY_ATTACK_ABORT_EN: a player leaving range during wind-up cancels the attack.
module enemy_attack_ctrl #(
  parameter int unsigned WINDUP_FRAMES   = 8,
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter int unsigned ATTACK_RANGE    = 20,
  parameter int unsigned ENEMY_SIZE      = 26,
  parameter int unsigned PLAYER_SIZE     = 26
) (
  input logic               clk,
  input logic               rst_n,
  enemy_attack_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WINDUP, STRIKE, COOLDOWN} state_t;

  localparam logic [9:0] RANGE         = 10'(ATTACK_RANGE);
  localparam logic [9:0] ENEMY_W       = 10'(ENEMY_SIZE);
  localparam logic [9:0] PLAYER_W      = 10'(PLAYER_SIZE);
  localparam logic [9:0] ENEMY_HALF    = 10'(ENEMY_SIZE / 2);
  localparam logic [9:0] PLAYER_HALF   = 10'(PLAYER_SIZE / 2);
  localparam logic [7:0] WINDUP_LAST   = 8'(WINDUP_FRAMES - 1);
  localparam logic [7:0] COOLDOWN_LAST = 8'(COOLDOWN_FRAMES - 1);

  logic [9:0] px, py, ex, ey;
  logic       in_range_x, in_range_y, in_range;

  assign px = {1'b0, bus.player_x};
  assign py = {1'b0, bus.player_y};
  assign ex = {1'b0, bus.enemy_x};
  assign ey = {1'b0, bus.enemy_y};

  // Both sides of each interval test are written as sums so nothing can wrap below zero.
  assign in_range_x = (px + PLAYER_W + RANGE >= ex) && (ex + ENEMY_W + RANGE >= px);
  assign in_range_y = (py + PLAYER_W + RANGE >= ey) && (ey + ENEMY_W + RANGE >= py);
  assign in_range   = in_range_x && in_range_y;

  logic [9:0] pcx, pcy, ecx, ecy, adx, ady;
  logic       player_right, player_below;
  logic [1:0] dir;

  // Dominant axis of the centre-to-centre delta; a tie goes to the horizontal axis.
  always_comb begin
    pcx          = px + PLAYER_HALF;
    pcy          = py + PLAYER_HALF;
    ecx          = ex + ENEMY_HALF;
    ecy          = ey + ENEMY_HALF;
    player_right = (pcx >= ecx);
    player_below = (pcy > ecy);
    adx          = player_right ? (pcx - ecx) : (ecx - pcx);
    ady          = (pcy >= ecy) ? (pcy - ecy) : (ecy - pcy);
    if (adx >= ady) dir = player_right ? 2'd3 : 2'd1;
    else            dir = player_below ? 2'd0 : 2'd2;
  end

  state_t     state;
  logic [7:0] frame_cnt;
  logic       attack_on_q;
  logic       attack_valid_q;
  logic [1:0] attack_dir_q;
  logic [7:0] attack_count_q;

  // A dead enemy drops to IDLE on the very next clock, regardless of frame ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      frame_cnt      <= 8'd0;
      attack_on_q    <= 1'b0;
      attack_valid_q <= 1'b0;
      attack_dir_q   <= 2'd0;
      attack_count_q <= 8'd0;
    end else if (!bus.enemy_alive) begin
      state          <= IDLE;
      frame_cnt      <= 8'd0;
      attack_on_q    <= 1'b0;
      attack_valid_q <= 1'b0;
    end else if (bus.game_frame_clk_rising_edge) begin
      case (state)
        IDLE: begin
          if (in_range) begin
            state        <= WINDUP;
            frame_cnt    <= 8'd0;
            attack_dir_q <= dir;
            attack_on_q  <= 1'b1;
          end
        end
        WINDUP: begin
`ifdef ENEMY_ATTACK_ABORT_EN
          if (!in_range) begin
            state       <= IDLE;
            frame_cnt   <= 8'd0;
            attack_on_q <= 1'b0;
          end else
`endif
          if (frame_cnt == WINDUP_LAST) begin
            state          <= STRIKE;
            attack_valid_q <= 1'b1;
          end else begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        STRIKE: begin
          state          <= COOLDOWN;
          frame_cnt      <= 8'd0;
          attack_on_q    <= 1'b0;
          attack_valid_q <= 1'b0;
          if (attack_count_q != 8'hFF) attack_count_q <= attack_count_q + 8'd1;
        end
        COOLDOWN: begin
          if (frame_cnt == COOLDOWN_LAST) begin
            state     <= IDLE;
            frame_cnt <= 8'd0;
          end else begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        default: begin
          state          <= IDLE;
          frame_cnt      <= 8'd0;
          attack_on_q    <= 1'b0;
          attack_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.attack_on        = attack_on_q;
  assign bus.attack_valid     = attack_valid_q;
  assign bus.attack_direction = attack_dir_q;
  assign bus.attack_count     = attack_count_q;

endmodule

// File: tb/tb_enemy_attack_ctrl.sv
`timescale 1ns/1ps
// Randomized bench for enemy_attack_ctrl: a frame-age reference model checked every clock, plus
// directed literal checks (default timing instance and a fast 1/1 instance for count saturation).
module tb_enemy_attack_ctrl;

  localparam int RANGE   = 20;
  localparam int E_SIZE  = 26;
  localparam int P_SIZE  = 26;
  localparam int A_WIND  = 8;
  localparam int A_COOL  = 30;
  localparam int B_WIND  = 1;
  localparam int B_COOL  = 1;
`ifdef ENEMY_ATTACK_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  typedef struct {
    bit         engaged;
    int         age;
    logic [1:0] dir;
    int         count;
  } model_t;

  logic clk;
  logic rst_n;
  logic rst_b_n;
  int   n_checks;
  int   n_fails;
  bit   b_done;

  enemy_attack_ctrl_if ifa ();
  enemy_attack_ctrl_if ifb ();

  enemy_attack_ctrl #(
    .WINDUP_FRAMES(A_WIND), .COOLDOWN_FRAMES(A_COOL), .ATTACK_RANGE(RANGE),
    .ENEMY_SIZE(E_SIZE), .PLAYER_SIZE(P_SIZE)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

  enemy_attack_ctrl #(
    .WINDUP_FRAMES(B_WIND), .COOLDOWN_FRAMES(B_COOL), .ATTACK_RANGE(RANGE),
    .ENEMY_SIZE(E_SIZE), .PLAYER_SIZE(P_SIZE)
  ) dut_b (.clk(clk), .rst_n(rst_b_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an engagement is just "frames elapsed since the in-range tick".
  function automatic bit model_in_range(int px, int py, int ex, int ey);
    return (px <= ex + E_SIZE + RANGE) && (px + P_SIZE >= ex - RANGE) &&
           (py <= ey + E_SIZE + RANGE) && (py + P_SIZE >= ey - RANGE);
  endfunction

  function automatic logic [1:0] model_dir(int px, int py, int ex, int ey);
    int dx, dy, adx, ady;
    dx  = (px + P_SIZE / 2) - (ex + E_SIZE / 2);
    dy  = (py + P_SIZE / 2) - (ey + E_SIZE / 2);
    adx = (dx < 0) ? -dx : dx;
    ady = (dy < 0) ? -dy : dy;
    if (adx >= ady) return (dx >= 0) ? 2'd3 : 2'd1;
    return (dy > 0) ? 2'd0 : 2'd2;
  endfunction

  function automatic model_t model_reset();
    model_t m;
    m.engaged = 1'b0;
    m.age     = 0;
    m.dir     = 2'd0;
    m.count   = 0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, int w, int c, logic alive, logic tick,
                                        bit rng, logic [1:0] d);
    model_t n;
    n = m;
    if (!alive) begin
      n.engaged = 1'b0;
    end else if (tick) begin
      if (!m.engaged) begin
        if (rng) begin
          n.engaged = 1'b1;
          n.age     = 0;
          n.dir     = d;
        end
      end else if (ABORT && m.age < w && !rng) begin
        n.engaged = 1'b0;
      end else begin
        n.age = m.age + 1;
        if (n.age == w + 1 && n.count < 255) n.count = n.count + 1;
        if (n.age == w + 1 + c) n.engaged = 1'b0;
      end
    end
    return n;
  endfunction

  model_t ma, mb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ma <= model_reset();
    else ma <= model_step(ma, A_WIND, A_COOL, ifa.enemy_alive, ifa.game_frame_clk_rising_edge,
                          model_in_range(int'(ifa.player_x), int'(ifa.player_y), int'(ifa.enemy_x), int'(ifa.enemy_y)),
                          model_dir(int'(ifa.player_x), int'(ifa.player_y), int'(ifa.enemy_x), int'(ifa.enemy_y)));
  end

  always @(posedge clk or negedge rst_b_n) begin
    if (!rst_b_n) mb <= model_reset();
    else mb <= model_step(mb, B_WIND, B_COOL, ifb.enemy_alive, ifb.game_frame_clk_rising_edge,
                          model_in_range(int'(ifb.player_x), int'(ifb.player_y), int'(ifb.enemy_x), int'(ifb.enemy_y)),
                          model_dir(int'(ifb.player_x), int'(ifb.player_y), int'(ifb.enemy_x), int'(ifb.enemy_y)));
  end

  task automatic check_output(input string name, input logic on, input logic valid,
                              input logic [1:0] dir, input logic [7:0] cnt,
                              input model_t m, input int w);
    logic exp_on, exp_valid;
    exp_on    = m.engaged && (m.age <= w);
    exp_valid = m.engaged && (m.age == w);
    n_checks++;
    if (on !== exp_on || valid !== exp_valid || dir !== m.dir || cnt !== 8'(m.count)) begin
      n_fails++;
      $display("[TB] FAIL %s at %0t: on/valid/dir/count actual %0b/%0b/%0d/%0d required %0b/%0b/%0d/%0d",
               name, $time, on, valid, dir, cnt, exp_on, exp_valid, m.dir, m.count);
    end
  endtask

  task automatic check_literal(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fails++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
    end
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1)
      check_output("model_a", ifa.attack_on, ifa.attack_valid, ifa.attack_direction, ifa.attack_count, ma, A_WIND);
    if (rst_b_n === 1'b1)
      check_output("model_b", ifb.attack_on, ifb.attack_valid, ifb.attack_direction, ifb.attack_count, mb, B_WIND);
  end

  // One game frame on instance A: tick for one clock, then gap-1 quiet clocks.
  task automatic apply_stimulus(input int gap);
    @(negedge clk);
    ifa.game_frame_clk_rising_edge = 1'b1;
    @(negedge clk);
    ifa.game_frame_clk_rising_edge = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic place_player(input int x, input int y);
    ifa.player_x = 9'(x);
    ifa.player_y = 9'(y);
  endtask

  // Instance B: player parked in range, fast timing, long enough to reach saturation.
  initial begin
    b_done = 1'b0;
    rst_b_n = 1'b1;
    ifb.game_frame_clk_rising_edge = 1'b0;
    ifb.enemy_x = 9'd200;
    ifb.enemy_y = 9'd200;
    ifb.player_x = 9'd210;
    ifb.player_y = 9'd200;
    ifb.enemy_alive = 1'b1;
    #2 rst_b_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_b_n = 1'b1;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      ifb.game_frame_clk_rising_edge = 1'b1;
      @(negedge clk);
      ifb.game_frame_clk_rising_edge = 1'b0;
      if (k == 7) check_literal("b_count_after_8_ticks", int'(ifb.attack_count), 2);
    end
    check_literal("b_count_saturated", int'(ifb.attack_count), 255);
    b_done = 1'b1;
  end

  initial begin
    int  saw_on;
    int  guard;
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b1;
    ifa.game_frame_clk_rising_edge = 1'b0;
    ifa.enemy_x = 9'd100;
    ifa.enemy_y = 9'd100;
    place_player(130, 100);
    ifa.enemy_alive = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_literal("reset_attack_on", int'(ifa.attack_on), 0);
    check_literal("reset_count", int'(ifa.attack_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed strike: enemy (100,100), player (130,100)");
    for (int k = 1; k <= 42; k++) begin
      apply_stimulus(10);
      if (k == 1) check_literal("windup_on_tick1", int'(ifa.attack_on), 1);
      if (k == 8) check_literal("valid_low_tick8", int'(ifa.attack_valid), 0);
      if (k == 9) begin
        check_literal("valid_high_tick9", int'(ifa.attack_valid), 1);
        check_literal("direction_right", int'(ifa.attack_direction), 3);
      end
      if (k == 10) begin
        check_literal("valid_low_tick10", int'(ifa.attack_valid), 0);
        check_literal("count_one", int'(ifa.attack_count), 1);
      end
      if (k == 39) check_literal("cooldown_on_low", int'(ifa.attack_on), 0);
      if (k == 41) check_literal("rewindup_tick41", int'(ifa.attack_on), 1);
    end

    $display("[TB] async reset mid wind-up");
    #3 rst_n = 1'b0;
    #1;
    check_literal("async_reset_on", int'(ifa.attack_on), 0);
    check_literal("async_reset_count", int'(ifa.attack_count), 0);
    check_literal("async_reset_dir", int'(ifa.attack_direction), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] enemy dies during strike");
    for (int k = 1; k <= 9; k++) apply_stimulus(2);
    check_literal("strike_before_death", int'(ifa.attack_valid), 1);
    ifa.enemy_alive = 1'b0;
    @(negedge clk);
    check_literal("death_valid", int'(ifa.attack_valid), 0);
    check_literal("death_count", int'(ifa.attack_count), 0);
    apply_stimulus(2);
    check_literal("dead_no_attack", int'(ifa.attack_on), 0);
    place_player(300, 300);
    ifa.enemy_alive = 1'b1;

    $display("[TB] player out of range");
    saw_on = 0;
    for (int k = 0; k < 100; k++) begin
      apply_stimulus(2);
      if (ifa.attack_on) saw_on++;
    end
    check_literal("out_of_range_on", saw_on, 0);

    $display("[TB] player dodges after wind-up tick 4");
    place_player(130, 100);
    for (int k = 1; k <= 10; k++) begin
      apply_stimulus(2);
      if (k == 4) place_player(300, 300);
    end
    check_literal("dodge_count", int'(ifa.attack_count), ABORT ? 0 : 1);

    $display("[TB] randomized play");
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 9) == 0) place_player(int'($urandom_range(250, 500)), int'($urandom_range(0, 500)));
        else place_player(int'($urandom_range(40, 170)), int'($urandom_range(40, 170)));
      end
      ifa.enemy_alive = ($urandom_range(0, 40) != 0);
      apply_stimulus(int'($urandom_range(1, 4)));
    end

    guard = 0;
    while (!b_done && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check_literal("b_finished", int'(b_done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
